port_mailbox: RTL

- Data-port responder (target side) for the seccpu data bus. It answers the CPU's data_address / read_strobe / write_strobe / data_out / data_in transactions inside a 4-register address window.
- It bridges the CPU to an external byte stream through two small FIFOs: RX (external -> CPU) and TX (CPU -> external).
- It drives the CPU intr line from programmable status conditions.
- At top level its rdata is muxed onto the CPU data_in whenever hit is high.

---
 rtl/port_mailbox_if.sv | 32 +++
 rtl/port_mailbox.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/port_mailbox_if.sv
// CPU data-port bus plus the RX/TX byte streams seen by the port_mailbox responder.
// slave = mailbox side, master = CPU/stream side.
interface port_mailbox_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] data_address;
  logic                  read_strobe;
  logic                  write_strobe;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  hit;
  logic                  intr;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport slave (
    input  data_address, read_strobe, write_strobe, data_out,
    input  rx_data, rx_valid, tx_ready,
    output rdata, hit, intr, rx_ready, tx_data, tx_valid
  );

  modport master (
    output data_address, read_strobe, write_strobe, data_out,
    output rx_data, rx_valid, tx_ready,
    input  rdata, hit, intr, rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/port_mailbox.sv
// 4-register CPU data-port mailbox bridging RX/TX byte FIFOs; rdata/hit combinational, intr registered.
// Backpressure: rx_ready drops when RX is full; CPU writes to a full TX are dropped and flagged.
module port_mailbox #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'hF0,
  parameter int                    FIFO_LOG2  = 2
) (
  input logic           clk,
  input logic           reset,
  port_mailbox_if.slave bus
);
  localparam int                 DEPTH    = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] FULL_CNT = (FIFO_LOG2 + 1)'(DEPTH);

  // Address decode: BASE_ADDR is 4-aligned, so the offset is simply the low two bits.
  logic       w_hit;
  logic [1:0] w_off;
  assign w_hit = (bus.data_address[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
  assign w_off = bus.data_address[1:0];

  logic w_rd_data, w_wr_data, w_wr_ctrl, w_wr_clr;
  assign w_rd_data = w_hit & bus.read_strobe  & (w_off == 2'd0);
  assign w_wr_data = w_hit & bus.write_strobe & (w_off == 2'd0);
  assign w_wr_ctrl = w_hit & bus.write_strobe & (w_off == 2'd2);
  assign w_wr_clr  = w_hit & bus.write_strobe & (w_off == 2'd3);

  // RX FIFO state
  logic [DATA_WIDTH-1:0] r_rx_mem [DEPTH];
  logic [FIFO_LOG2-1:0]  r_rx_wptr, r_rx_rptr;
  logic [FIFO_LOG2:0]    r_rx_cnt;
  logic                  w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;

  // TX FIFO state
  logic [DATA_WIDTH-1:0] r_tx_mem [DEPTH];
  logic [FIFO_LOG2-1:0]  r_tx_wptr, r_tx_rptr;
  logic [FIFO_LOG2:0]    r_tx_cnt;
  logic                  w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;

  logic [2:0] r_ctrl;
  logic       r_rx_ovf, r_tx_ovf, r_rx_udf, r_intr;
  logic       w_rx_ovf_set, w_tx_ovf_set, w_rx_udf_set;

  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);

  assign w_rx_push = bus.rx_valid & ~w_rx_full;
  assign w_rx_pop  = w_rd_data & ~w_rx_empty;
  assign w_tx_push = w_wr_data & ~w_tx_full;
  assign w_tx_pop  = ~w_tx_empty & bus.tx_ready;

  // A stalled external byte only counts as an overflow if the CPU is not freeing a slot this cycle.
  assign w_rx_ovf_set = bus.rx_valid & w_rx_full & ~w_rx_pop;
  assign w_tx_ovf_set = w_wr_data & w_tx_full;
  assign w_rx_udf_set = w_rd_data & w_rx_empty;

  assign bus.rx_ready = ~w_rx_full;
  assign bus.tx_valid = ~w_tx_empty;
  assign bus.tx_data  = r_tx_mem[r_tx_rptr];
  assign bus.hit      = w_hit;
  assign bus.intr     = r_intr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && w_rx_push) r_rx_mem[r_rx_wptr] <= bus.rx_data;
    if (!reset && w_tx_push) r_tx_mem[r_tx_wptr] <= bus.data_out;
  end

  // Sticky flags: a set event on the same cycle as a CLEAR write wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl   <= '0;
      r_rx_ovf <= 1'b0;
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
      r_intr   <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= bus.data_out[2:0];
      r_rx_ovf <= w_rx_ovf_set | (r_rx_ovf & ~(w_wr_clr & bus.data_out[4]));
      r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~(w_wr_clr & bus.data_out[5]));
      r_rx_udf <= w_rx_udf_set | (r_rx_udf & ~(w_wr_clr & bus.data_out[6]));
      r_intr   <= (r_ctrl[0] & ~w_rx_empty)
                | (r_ctrl[1] & w_tx_empty)
                | (r_ctrl[2] & (r_rx_ovf | r_tx_ovf | r_rx_udf));
    end
  end

  logic [7:0] w_status;
  assign w_status = {r_intr, r_rx_udf, r_tx_ovf, r_rx_ovf,
                     w_tx_full, w_tx_empty, w_rx_full, ~w_rx_empty};

  logic [DATA_WIDTH-1:0] w_rdata;
  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_off)
        2'd0:    if (!w_rx_empty) w_rdata = r_rx_mem[r_rx_rptr];
        2'd1:    w_rdata[7:0] = w_status;
        2'd2:    w_rdata[2:0] = r_ctrl;
        default: w_rdata = '0;
      endcase
    end
  end
  assign bus.rdata = w_rdata;

  // Write-data bits with no register behind them.
  logic w_unused;
  assign w_unused = ^{bus.data_out[DATA_WIDTH-1:7], bus.data_out[3]};
endmodule
